// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 16-bit Fibonacci PRBS generator (x^16+x^14+x^13+x^11+1).
// Seeds from the incoming stream, verifies LOCK_COUNT predictions, then flywheels and counts errors.
module lfsr_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_word,
    output logic        locked,
    output logic        err,
    output logic        sync_lost,
    output logic [15:0] err_count,
    output logic [31:0] word_count
);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    state_t      state;
    logic [15:0] predicted;
    logic [3:0]  match_cnt;
    logic [3:0]  miss_cnt;
    logic [3:0]  match_inc;
    logic [3:0]  miss_inc;
    logic        hit;
    logic        zero_word;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    assign match_inc = match_cnt + 4'd1;
    assign miss_inc  = miss_cnt + 4'd1;
    assign hit       = (in_word == predicted);
    assign zero_word = (in_word == 16'h0000);

    // Pulses default low every edge; only valid words move predicted, counters or the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            predicted  <= 16'h0000;
            match_cnt  <= 4'd0;
            miss_cnt   <= 4'd0;
            locked     <= 1'b0;
            err        <= 1'b0;
            sync_lost  <= 1'b0;
            err_count  <= 16'h0000;
            word_count <= 32'd0;
        end else begin
            err       <= 1'b0;
            sync_lost <= 1'b0;
            if (in_valid) begin
                case (state)
                    SEARCH: begin
                        if (!zero_word) begin
                            predicted <= lfsr_next(in_word);
                            match_cnt <= 4'd0;
                            state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (hit) begin
                            predicted <= lfsr_next(in_word);
                            match_cnt <= match_inc;
                            if (match_inc == LOCK_N) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= 4'd0;
                            end
                        end else if (!zero_word) begin
                            predicted <= lfsr_next(in_word);
                            match_cnt <= 4'd0;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: advance from our own prediction so corrupt words never reseed.
                        predicted  <= lfsr_next(predicted);
                        word_count <= word_count + 32'd1;
                        if (hit) begin
                            miss_cnt <= 4'd0;
                        end else begin
                            err      <= 1'b1;
                            miss_cnt <= miss_inc;
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                            if (miss_inc == LOSS_N) begin
                                sync_lost <= 1'b1;
                                locked    <= 1'b0;
                                state     <= SEARCH;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: the driver queues expected outputs per stimulus cycle,
// and a monitor pops and compares them one cycle later.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_word;
    logic        locked;
    logic        err;
    logic        sync_lost;
    logic [15:0] err_count;
    logic [31:0] word_count;

    typedef struct packed {
        logic        exp_locked;
        logic        exp_err;
        logic        exp_sync;
        logic [15:0] exp_ec;
        logic [31:0] exp_wc;
        logic [31:0] step;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] step = 0;
    logic [15:0] exp_ec;
    logic [31:0] exp_wc;
    logic [15:0] cur;
    logic [15:0] target;

    lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .locked     (locked),
        .err        (err),
        .sync_lost  (sync_lost),
        .err_count  (err_count),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] stp,
                               input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, stp, got, want);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] w,
                                 input logic el, input logic ee, input logic es);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_word  = w;
        step     = step + 1;
        e.exp_locked = el;
        e.exp_err    = ee;
        e.exp_sync   = es;
        e.exp_ec     = exp_ec;
        e.exp_wc     = exp_wc;
        e.step       = step;
        q.push_back(e);
    endtask

    task automatic sendWord(input logic el);
        applyStimulus(1'b1, cur, el, 1'b0, 1'b0);
        cur = lfsr_next(cur);
    endtask

    task automatic lockedGood();
        exp_wc = exp_wc + 1;
        applyStimulus(1'b1, cur, 1'b1, 1'b0, 1'b0);
        cur = lfsr_next(cur);
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        exp_ec = 16'h0000;
        exp_wc = 32'd0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " locked"},     step, {31'd0, locked},    32'd0);
        checkOutput({tag, " err"},        step, {31'd0, err},       32'd0);
        checkOutput({tag, " sync_lost"},  step, {31'd0, sync_lost}, 32'd0);
        checkOutput({tag, " err_count"},  step, {16'd0, err_count}, 32'd0);
        checkOutput({tag, " word_count"}, step, word_count,         32'd0);
    endtask

    // Monitor: every cycle the driver queued an expectation, compare one edge later.
    always @(posedge clk) begin
        if (q.size() > 0) begin
            #1;
            mon_e = q.pop_front();
            checkOutput("locked",     mon_e.step, {31'd0, locked},    {31'd0, mon_e.exp_locked});
            checkOutput("err",        mon_e.step, {31'd0, err},       {31'd0, mon_e.exp_err});
            checkOutput("sync_lost",  mon_e.step, {31'd0, sync_lost}, {31'd0, mon_e.exp_sync});
            checkOutput("err_count",  mon_e.step, {16'd0, err_count}, {16'd0, mon_e.exp_ec});
            checkOutput("word_count", mon_e.step, word_count,         mon_e.exp_wc);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_word  = 16'h0000;
        exp_ec   = 16'h0000;
        exp_wc   = 32'd0;
        cur      = 16'h0000;
        target   = 16'h0000;
        #12;
        checkAllZero("por");
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] zero words in SEARCH");
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] acquisition with 3-cycle gap after 2nd word");
        applyStimulus(1'b1, 16'h3c28, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h7851, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
        cur = lfsr_next(16'h7851);
        sendWord(1'b0);
        sendWord(1'b0);
        sendWord(1'b1);

        $display("[TB] single bit error while locked");
        lockedGood();
        lockedGood();
        exp_wc = exp_wc + 1;
        exp_ec = exp_ec + 1;
        applyStimulus(1'b1, cur ^ 16'h0001, 1'b1, 1'b1, 1'b0);
        cur = lfsr_next(cur);
        applyStimulus(1'b0, cur, 1'b1, 1'b0, 1'b0);
        lockedGood();
        lockedGood();
        lockedGood();
        drain();

        $display("[TB] asynchronous reset mid-cycle");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkAllZero("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        exp_ec = 16'h0000;
        exp_wc = 32'd0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0);

        $display("[TB] loss of sync and relock");
        cur = 16'hace1;
        for (int i = 0; i < 4; i++) sendWord(1'b0);
        sendWord(1'b1);
        lockedGood();
        for (int i = 0; i < 3; i++) begin
            exp_wc = exp_wc + 1;
            exp_ec = exp_ec + 1;
            applyStimulus(1'b1, 16'hFFFF, (i < 2), 1'b1, (i == 2));
            cur = lfsr_next(cur);
        end
        cur = 16'h5a5a;
        for (int i = 0; i < 4; i++) sendWord(1'b0);
        sendWord(1'b1);
        lockedGood();
        drain();

        $display("[TB] zero word while locked");
        doReset();
        cur = 16'h0b0b;
        for (int i = 0; i < 4; i++) sendWord(1'b0);
        sendWord(1'b1);
        lockedGood();
        exp_wc = exp_wc + 1;
        exp_ec = exp_ec + 1;
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        cur = lfsr_next(cur);
        lockedGood();
        lockedGood();
        drain();

        $display("[TB] full period from seed 3c28");
        doReset();
        cur = 16'h3c28;
        for (int i = 0; i < 4; i++) sendWord(1'b0);
        sendWord(1'b1);
        target = cur;
        for (int i = 0; i < 65535; i++) lockedGood();
        drain();
        checkOutput("period word_count", step, word_count, 32'd65535);
        checkOutput("period predicted", step, {16'd0, dut.predicted}, {16'd0, target});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 16-bit Fibonacci LFSR generator. It consumes the generator's 16-bit state word stream, self-synchronises to it, and predicts each next word. Once locked, it flags and counts mismatches and drops lock after repeated misses. It sits at the sink end of the PRBS test path, so the generator/checker pair can run link and datapath BIST without a shared seed.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive correct predictions required to declare lock (1..15).
- LOSS_COUNT, 3: consecutive mispredictions in LOCKED that drop lock (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  in_word is sampled on this edge when high.
- in_word  in  16  received LFSR state word.
- locked  out  1  registered; high while FSM is in LOCKED.
- err  out  1  registered one-cycle pulse per mispredicted word while LOCKED.
- sync_lost  out  1  registered one-cycle pulse on the LOCKED->SEARCH transition.
- err_count  out  16  mismatches while LOCKED; saturates at 16'hFFFF.
- word_count  out  32  valid words checked while LOCKED; wraps modulo 2^32.

## Operation
- Polynomial x^16+x^14+x^13+x^11+1. Define next(s) = {s[14:0], s[15]^s[13]^s[12]^s[10]}. Period is 65535; 16'h0000 is the lockup state and is never a legal word.
- Internal state:
  - predicted[15:0], the expected next word.
  - match_cnt[3:0], consecutive correct predictions.
  - miss_cnt[3:0], consecutive mispredictions.
  - FSM: SEARCH, VERIFY, LOCKED.
- Cycles with in_valid low change nothing: predicted does not advance, and the counters and FSM hold.
- SEARCH:
  - Valid nonzero word: predicted <= next(in_word), match_cnt <= 0, go to VERIFY.
  - Valid zero word: ignored, stay in SEARCH.
- VERIFY, on each valid word:
  - in_word == predicted: match_cnt++ and predicted <= next(in_word). When match_cnt reaches LOCK_COUNT, go to LOCKED with miss_cnt <= 0.
  - Mismatch and in_word nonzero: reseed with predicted <= next(in_word) and match_cnt <= 0, stay in VERIFY.
  - Mismatch and in_word zero: go to SEARCH.
- LOCKED (flywheel mode), on each valid word:
  - predicted <= next(predicted) regardless of in_word, so the checker never reseeds from corrupt data.
  - word_count++.
  - Match: miss_cnt <= 0.
  - Mismatch, including a zero word: err pulse, err_count++ (saturating), miss_cnt++.
  - When miss_cnt reaches LOSS_COUNT: sync_lost pulse, go to SEARCH. err_count and word_count hold their values.
- err_count and word_count clear only on reset.

## Timing
- Reset values:
  - FSM = SEARCH.
  - predicted = 0, match_cnt = 0, miss_cnt = 0.
  - locked = 0, err = 0, sync_lost = 0, err_count = 0, word_count = 0.
- Reset asserted mid-operation clears everything asynchronously. After deassertion, the first valid edge is treated as a SEARCH seed.
- Latency: err and sync_lost are high during the cycle after the edge that sampled the offending word, and low the cycle after that unless re-triggered.
- locked rises on the edge that samples the LOCK_COUNT-th matching word. It falls on the same edge that raises sync_lost.
- Lock acquisition with continuous valid takes 1 + LOCK_COUNT words (5 by default).
- When the mismatch that reaches LOSS_COUNT is sampled, err and sync_lost are both high in the same cycle.
- Back-to-back valid words are supported at full rate: one word per clock, no backpressure.

## Test plan
- Reset and idle: assert reset asynchronously mid-cycle. All outputs read 0 immediately and stay 0 with in_valid=0 for 10 cycles.
- Acquisition: feed 16'h3c28, 16'h7851, then three more successive next() words, one per clock. locked rises after the 5th edge; err, err_count and word_count stay 0. A 3-cycle in_valid gap inserted after the 2nd word delays lock by exactly 3 cycles.
- Single error while locked: after lock, replace one word with its bit 0 flipped. err pulses for one cycle, err_count=1, locked stays 1, and subsequent correct words match (flywheel check).
- Loss of sync: after lock, feed 3 consecutive words of 16'hFFFF. err pulses 3 times, err_count=3, sync_lost and locked fall on the 3rd. A new correct stream relocks after 5 words with err_count still 3.
- Zero word handling: 16'h0000 in SEARCH leaves the FSM in SEARCH. A single zero word in LOCKED gives err=1, err_count=1, and lock is held.
- Full period: lock on seed 16'h3c28 and run 65535 further words. No err occurs, word_count=65535 at the end, and predicted returns to the post-seed value.
